// File: rtl/cpu_pkg.sv
// Shared constants for the writeback stage: result-select codes, load funct3
// codes, FSM state encoding and the held MEM/WB control fields.
package cpu_pkg;

  localparam logic [1:0] WBSEL_ALU  = 2'b00;
  localparam logic [1:0] WBSEL_LOAD = 2'b01;
  localparam logic [1:0] WBSEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    RETIRE    = 2'd1,
    WAIT_LOAD = 2'd2
  } wb_state_e;

  // Control part of the MEM/WB entry (datapath words are held separately
  // so that the struct stays independent of XLEN).
  typedef struct packed {
    logic       regwrite;
    logic [4:0] rd;
    logic [1:0] wbsel;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } wb_ctrl_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB handshake bundle.
//   master: MEM stage, drives mem_valid and the instruction fields.
//   slave : WB stage, drives mem_ready.
interface wb_stage_if #(parameter int XLEN = 32);
  logic            mem_valid;
  logic            mem_ready;
  logic            mem_regwrite;
  logic [4:0]      mem_rd;
  logic [1:0]      mem_wbsel;
  logic [2:0]      mem_funct3;
  logic [1:0]      mem_addr_lo;
  logic [XLEN-1:0] mem_alu_result;
  logic [XLEN-1:0] mem_pc4;

  modport master (output mem_valid, mem_regwrite, mem_rd, mem_wbsel, mem_funct3,
                         mem_addr_lo, mem_alu_result, mem_pc4,
                  input  mem_ready);
  modport slave  (input  mem_valid, mem_regwrite, mem_rd, mem_wbsel, mem_funct3,
                         mem_addr_lo, mem_alu_result, mem_pc4,
                  output mem_ready);
endinterface

// File: rtl/load_align.sv
// Load data formatter (combinational).
//   funct3  : load type (LB/LH/LW/LBU/LHU; others treated as LW)
//   addr_lo : byte offset within the word
//   rdata   : raw aligned word from data memory
//   data    : extracted, sign/zero-extended result
module load_align import cpu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;

  // Halfword select ignores addr_lo[0]: misaligned halves fall back to the
  // containing aligned halfword.
  assign b = 8'(rdata >> {addr_lo, 3'b000});
  assign h = 16'(rdata >> {addr_lo[1], 4'b0000});

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){b[7]}}, b};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, b};
      F3_LH:   data = {{(XLEN-16){h[15]}}, h};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, h};
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage. Holds one MEM/WB entry, selects its result (ALU, aligned
// load data, PC+4), waits for the load response when needed and drives the
// register-file write port in the retiring cycle. Counts retirements.
//   clk, rst      : clock, async active-high reset
//   mem           : MEM handshake + instruction fields (slave side)
//   dmem_rvalid   : one-cycle load response strobe
//   dmem_rdata    : raw load word
//   RegWrite/WriteAddr/WriteData : register-file write port
//   instret       : retired-instruction counter (wraps)
module wb_stage import cpu_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  wb_stage_if.slave        mem,
  input  logic             dmem_rvalid,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             RegWrite,
  output logic [4:0]       WriteAddr,
  output logic [XLEN-1:0]  WriteData,
  output logic [CNT_W-1:0] instret
);
  wb_state_e       state, state_n;
  wb_ctrl_t        ent;
  logic [XLEN-1:0] ent_alu, ent_pc4;
  logic [XLEN-1:0] ld_data, result;
  logic            retire, xfer;

  // Retirement frees the entry, so a new instruction can be taken in the
  // same cycle; this keeps back-to-back non-loads at one per cycle.
  assign retire    = (state == RETIRE) | ((state == WAIT_LOAD) & dmem_rvalid);
  assign mem.mem_ready = (state == EMPTY) | retire;
  assign xfer      = mem.mem_valid & mem.mem_ready;

  always_comb begin
    state_n = state;
    if (xfer)
      state_n = (mem.mem_wbsel == WBSEL_LOAD) ? WAIT_LOAD : RETIRE;
    else if (retire)
      state_n = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      ent     <= '0;
      ent_alu <= '0;
      ent_pc4 <= '0;
      instret <= '0;
    end else begin
      state <= state_n;
      if (xfer) begin
        ent     <= '{regwrite: mem.mem_regwrite, rd: mem.mem_rd, wbsel: mem.mem_wbsel,
                     funct3: mem.mem_funct3, addr_lo: mem.mem_addr_lo};
        ent_alu <= mem.mem_alu_result;
        ent_pc4 <= mem.mem_pc4;
      end
      if (retire)
        instret <= instret + 1'b1;
    end
  end

  load_align #(.XLEN(XLEN)) u_align (
    .funct3  (ent.funct3),
    .addr_lo (ent.addr_lo),
    .rdata   (dmem_rdata),
    .data    (ld_data)
  );

  always_comb begin
    case (ent.wbsel)
      WBSEL_LOAD: result = ld_data;
      WBSEL_PC4:  result = ent_pc4;
      default:    result = ent_alu;
    endcase
  end

  assign RegWrite  = retire & ent.regwrite & (ent.rd != 5'd0);
  assign WriteAddr = RegWrite ? ent.rd : 5'd0;
  assign WriteData = RegWrite ? result : '0;
endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  localparam int XLEN = 32;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;
  logic RegWrite;
  logic [4:0] WriteAddr;
  logic [XLEN-1:0] WriteData;
  logic [CNT_W-1:0] instret;

  int tests = 0;
  int fails = 0;
  logic [CNT_W-1:0] ref_instret = '0;

  wb_stage_if #(.XLEN(XLEN)) mif ();

  wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mem(mif.slave),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .instret(instret)
  );

  always #5 clk = ~clk;

  // Reference load formatting computed from byte/halfword arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] alo,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (int'(alo) * 8)) & 32'hFF;
    h = (w >> ((int'(alo) / 2) * 16)) & 32'hFFFF;
    case (f3)
      3'b000: return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'b001: return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'b100: return b;
      3'b101: return h;
      default: return w;
    endcase
  endfunction

  task automatic scramble_mem;
    mif.mem_regwrite   = 1'($urandom);
    mif.mem_rd         = 5'($urandom);
    mif.mem_wbsel      = 2'($urandom);
    mif.mem_funct3     = 3'($urandom);
    mif.mem_addr_lo    = 2'($urandom);
    mif.mem_alu_result = $urandom;
    mif.mem_pc4        = $urandom;
  endtask

  // Issue one instruction from an EMPTY stage, supply the load response after
  // dly stall cycles, and check the write port, stall and instret.
  task automatic run_op(input logic rw, input logic [4:0] rd, input logic [1:0] ws,
                        input logic [2:0] f3, input logic [1:0] alo,
                        input logic [31:0] alu, input logic [31:0] pc4,
                        input logic [31:0] rdata, input int dly, input string nm);
    logic [31:0] exp_d;
    logic exp_we;
    exp_we = rw && (rd != 5'd0);
    exp_d = (ws == 2'b01) ? ref_load(f3, alo, rdata) : (ws == 2'b10) ? pc4 : alu;
    mif.mem_valid = 1'b1; mif.mem_regwrite = rw; mif.mem_rd = rd; mif.mem_wbsel = ws;
    mif.mem_funct3 = f3; mif.mem_addr_lo = alo; mif.mem_alu_result = alu; mif.mem_pc4 = pc4;
    tests++;
    if (mif.mem_ready !== 1'b1) begin
      fails++; $display("FAIL %s ready_at_issue got=%b exp=1", nm, mif.mem_ready);
    end
    @(negedge clk);
    mif.mem_valid = 1'b0;
    scramble_mem();
    if (ws == 2'b01) begin
      for (int k = 0; k < dly; k++) begin
        tests++;
        if (mif.mem_ready !== 1'b0 || RegWrite !== 1'b0) begin
          fails++; $display("FAIL %s stall%0d ready=%b we=%b exp ready=0 we=0", nm, k, mif.mem_ready, RegWrite);
        end
        @(negedge clk);
      end
      dmem_rvalid = 1'b1; dmem_rdata = rdata;
      #1;
    end
    tests++;
    if (RegWrite !== exp_we || WriteAddr !== (exp_we ? rd : 5'd0) ||
        WriteData !== (exp_we ? exp_d : 32'd0) || mif.mem_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s write got we=%b a=%0d d=%h rdy=%b exp we=%b a=%0d d=%h rdy=1", nm,
               RegWrite, WriteAddr, WriteData, mif.mem_ready, exp_we, exp_we ? rd : 5'd0,
               exp_we ? exp_d : 32'd0);
    end
    ref_instret++;
    @(negedge clk);
    dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    tests++;
    if (instret !== ref_instret || RegWrite !== 1'b0) begin
      fails++; $display("FAIL %s instret got=%0d exp=%0d we=%b", nm, instret, ref_instret, RegWrite);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; mif.mem_valid = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0; scramble_mem();
    repeat (2) @(negedge clk);
    tests++;
    if (RegWrite !== 1'b0 || WriteAddr !== 5'd0 || WriteData !== 32'd0 ||
        instret !== '0 || mif.mem_ready !== 1'b1) begin
      fails++; $display("FAIL reset we=%b a=%0d d=%h cnt=%0d rdy=%b exp 0/0/0/0/1",
                        RegWrite, WriteAddr, WriteData, instret, mif.mem_ready);
    end
    rst = 1'b0; ref_instret = '0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    run_op(1'b1, 5'd5, 2'b00, 3'b000, 2'd0, 32'h1234, 32'h0, 32'h0, 0, "alu_rd5");
    run_op(1'b1, 5'd3, 2'b01, 3'b000, 2'd2, 32'h0, 32'h0, 32'h0080_0000, 3, "lb_sext");
    run_op(1'b1, 5'd4, 2'b01, 3'b101, 2'd2, 32'h0, 32'h0, 32'h8001_0000, 1, "lhu");
    run_op(1'b1, 5'd0, 2'b00, 3'b000, 2'd0, 32'hDEAD, 32'h0, 32'h0, 0, "rd0");
    run_op(1'b0, 5'd7, 2'b10, 3'b000, 2'd0, 32'h1, 32'h200, 32'h0, 0, "no_regwrite");
    run_op(1'b1, 5'd9, 2'b11, 3'b000, 2'd0, 32'hABCD, 32'h0, 32'h0, 0, "wbsel11");
    run_op(1'b1, 5'd8, 2'b01, 3'b111, 2'd3, 32'h0, 32'h0, 32'hCAFE_F00D, 2, "undef_f3");
  endtask

  task automatic test_back_to_back;
    logic [1:0] ws [4] = '{2'b00, 2'b00, 2'b00, 2'b10};
    logic [31:0] alu [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    logic [31:0] exp_d;
    for (int i = 0; i < 4; i++) begin
      mif.mem_valid = 1'b1; mif.mem_regwrite = 1'b1; mif.mem_rd = 5'(10 + i);
      mif.mem_wbsel = ws[i]; mif.mem_funct3 = 3'b010; mif.mem_addr_lo = 2'd0;
      mif.mem_alu_result = alu[i]; mif.mem_pc4 = 32'h104;
      exp_d = (i == 3) ? 32'h104 : alu[i];
      @(negedge clk);
      if (i == 3) mif.mem_valid = 1'b0;
      tests++;
      if (RegWrite !== 1'b1 || WriteAddr !== 5'(10 + i) || WriteData !== exp_d || mif.mem_ready !== 1'b1) begin
        fails++; $display("FAIL b2b%0d we=%b a=%0d d=%h rdy=%b exp 1/%0d/%h/1",
                          i, RegWrite, WriteAddr, WriteData, mif.mem_ready, 10 + i, exp_d);
      end
      ref_instret++;
    end
    @(negedge clk);
    tests++;
    if (instret !== ref_instret || RegWrite !== 1'b0) begin
      fails++; $display("FAIL b2b_instret got=%0d exp=%0d we=%b", instret, ref_instret, RegWrite);
    end
  endtask

  task automatic test_random;
    logic [1:0] ws;
    logic [2:0] f3;
    for (int n = 0; n < 40; n++) begin
      // Idle cycle with a stray response: must be ignored.
      if ($urandom_range(0, 2) == 0) begin
        dmem_rvalid = 1'b1; dmem_rdata = $urandom;
        #1;
        tests++;
        if (RegWrite !== 1'b0 || mif.mem_ready !== 1'b1) begin
          fails++; $display("FAIL stray_rvalid%0d we=%b rdy=%b exp 0/1", n, RegWrite, mif.mem_ready);
        end
        @(negedge clk);
        dmem_rvalid = 1'b0;
        tests++;
        if (instret !== ref_instret) begin
          fails++; $display("FAIL stray_cnt%0d got=%0d exp=%0d", n, instret, ref_instret);
        end
      end
      ws = 2'($urandom);
      f3 = 3'($urandom);
      run_op(1'($urandom_range(0, 3) != 0), 5'($urandom), ws, f3, 2'($urandom),
             $urandom, $urandom, $urandom, $urandom_range(0, 3), "rand");
    end
  endtask

  task automatic test_reset_wait_load;
    mif.mem_valid = 1'b1; mif.mem_regwrite = 1'b1; mif.mem_rd = 5'd6; mif.mem_wbsel = 2'b01;
    mif.mem_funct3 = 3'b010; mif.mem_addr_lo = 2'd0;
    @(negedge clk);
    mif.mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ref_instret = '0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    #1;
    tests++;
    if (RegWrite !== 1'b0 || mif.mem_ready !== 1'b1 || instret !== '0) begin
      fails++; $display("FAIL rst_wait we=%b rdy=%b cnt=%0d exp 0/1/0", RegWrite, mif.mem_ready, instret);
    end
    @(negedge clk);
    dmem_rvalid = 1'b0;
    tests++;
    if (instret !== '0 || RegWrite !== 1'b0) begin
      fails++; $display("FAIL rst_wait_cnt got=%0d exp=0 we=%b", instret, RegWrite);
    end
    run_op(1'b1, 5'd2, 2'b00, 3'b000, 2'd0, 32'h77, 32'h0, 32'h0, 0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_wait_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
